// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle ARM-style core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and enable.
module multicycle_ctrl #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000,
  parameter bit         ALLOW_IMM7 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  state_t     state, state_next;
  logic       cond_ex;
  logic       flag_we;
  logic [1:0] alu_op;
  logic [3:0] cmd;
  logic       i_bit, s_bit, is_cmp;

  assign cmd    = Funct[4:1];
  assign i_bit  = Funct[5];
  assign s_bit  = Funct[0];
  assign is_cmp = (cmd == 4'b1010);

  // Condition check against the stored NZCV; 1111 never executes.
  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'b0000: cond_ex = Flags[2];
      4'b0001: cond_ex = !Flags[2];
      4'b0010: cond_ex = Flags[1];
      4'b0011: cond_ex = !Flags[1];
      4'b0100: cond_ex = Flags[3];
      4'b0101: cond_ex = !Flags[3];
      4'b0110: cond_ex = Flags[0];
      4'b0111: cond_ex = !Flags[0];
      4'b1000: cond_ex = Flags[1] && !Flags[2];
      4'b1001: cond_ex = !Flags[1] || Flags[2];
      4'b1010: cond_ex = (Flags[3] == Flags[0]);
      4'b1011: cond_ex = (Flags[3] != Flags[0]);
      4'b1100: cond_ex = !Flags[2] && (Flags[3] == Flags[0]);
      4'b1101: cond_ex = Flags[2] || (Flags[3] != Flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    if (Op != 2'b11) begin
      unique case (cmd)
        4'b0010, 4'b1010: alu_op = ALU_SUB;
        4'b0000:          alu_op = ALU_AND;
        4'b1100:          alu_op = ALU_ORR;
        default:          alu_op = ALU_ADD;
      endcase
    end
  end

  // NOTE: state and flags are registered with non-blocking assignments so every
  // always_ff reads the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      Flags <= FLAGS_INIT;
    end else begin
      state <= state_next;
      if (flag_we) Flags <= ALUFlags;
    end
  end

  // NOTE: every output and next-state term is defaulted first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next = state;
    flag_we    = 1'b0;
    MemReq     = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;

    // Asserted reset forces every enable low combinationally, aborting mid-access.
    if (reset) begin
      RegSrc = {(Op == 2'b01) && !s_bit, (Op == 2'b10)};
      unique case (state)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ImmSrc  = Op;
          if (!cond_ex) begin
            state_next = S_FETCH;
          end else begin
            unique case (Op)
              2'b01:   state_next = S_MEMADR;
              2'b10:   state_next = S_BRANCH;
              2'b00:   state_next = i_bit ? S_EXECI : S_EXECR;
              default: state_next = ALLOW_IMM7 ? S_EXECI : S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          ALUSrcB    = 2'b01;
          ImmSrc     = Op;
          state_next = s_bit ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
          if (MemReady) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          MemReq   = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          if (MemReady) state_next = S_FETCH;
        end
        S_EXECR: begin
          ALUControl = alu_op;
          state_next = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcB    = 2'b01;
          ImmSrc     = Op;
          ALUControl = alu_op;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite   = !is_cmp;
          PCWrite    = !is_cmp && (Rd == 4'd15);
          flag_we    = s_bit || is_cmp;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b01;
          ImmSrc     = 2'b10;
          ResultSrc  = 2'b10;
          PCWrite    = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle ARM-style core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives ImmSrc to the immediate extender, plus all datapath mux selects, write enables and the NZCV flag register.
- Sits between the instruction register, the shared instruction/data memory port and the datapath.

Parameters:
FLAGS_INIT, 4'b0000, reset value of the stored NZCV flags.
ALLOW_IMM7, 1, when 1 Op=11 executes as a signed-7-bit-immediate ADD; when 0 Op=11 is undefined and retires as a NOP.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Cond  in  4  instruction condition field Instr[31:28]
Op  in  2  Instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 imm7
Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (data-proc) or L (memory)
Rd  in  4  Instr[15:12]
ALUFlags  in  4  NZCV from the ALU in the current cycle
MemReady  in  1  memory completes the pending access this cycle
MemReq  out  1  memory access request
PCWrite  out  1  PC register enable
IRWrite  out  1  instruction register enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
AdrSrc  out  1  0=PC, 1=ALU result as memory address
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  1  0=Rn, 1=PC
ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=constant 4
ImmSrc  out  2  extender mode: 00 dp-imm, 01 mem 12-bit, 10 branch, 11 signed 7-bit
RegSrc  out  2  register-address selects for stores and branches
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
Flags  out  4  stored NZCV

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. State register and Flags are async-cleared by reset=0 to FETCH and FLAGS_INIT.
- Outputs are decoded combinationally from state, Op, Funct, Cond, Flags and MemReady. While reset=0, all enables and MemReq are 0 and all selects are 0.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - Holds while MemReady=0.
  - When MemReady=1: IRWrite=1, PCWrite=1 (unconditional), next state DECODE.
- DECODE:
  - Computes PC+8 (ALUSrcA=1, ALUSrcB=10).
  - ImmSrc follows Op: 00→00, 01→01, 10→10, 11→11.
  - CondEx is evaluated from Cond and Flags using the ARM EQ..AL table (1111 counts as false).
  - If CondEx=0, next state FETCH with no writes.
  - Otherwise: Op=01 → MEMADR; Op=10 → BRANCH; Op=00 with I=1 → EXECI; Op=00 with I=0 → EXECR; Op=11 → EXECI if ALLOW_IMM7, else FETCH.
- MEMADR: ALUSrcB=01, ALUControl=ADD. Next state MEMRD if L=1, else MEMWR.
- MEMRD: MemReq=1, AdrSrc=1. Holds until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWR: MemReq=1, AdrSrc=1, MemWrite=1 asserted every wait cycle. Goes to FETCH on MemReady=1.
- EXECR / EXECI:
  - ALUSrcB=00 or 01 respectively.
  - ALUControl from cmd: 0100 ADD, 0010 SUB, 1010 CMP (SUB), 0000 AND, 1100 ORR. Other cmd values use ADD.
  - Op=11 always uses ADD.
  - Next state ALUWB.
- ALUWB:
  - ResultSrc=00.
  - RegWrite=1 unless cmd is CMP.
  - If S=1 (or cmd is CMP), Flags <= ALUFlags at the clock edge ending ALUWB.
  - If Rd=15 and RegWrite: PCWrite=1, ResultSrc=00.
  - Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1, then FETCH.
- Flags change only in ALUWB. Memory and branch instructions never alter Flags.
- Reset asserted mid-instruction aborts immediately. No write enable is asserted after the reset edge. After release, the FSM restarts at FETCH.

Test Plan:
- Reset=0 for 2 cycles, then release with MemReady=1 → state FETCH, Flags=0000, IRWrite=1 and PCWrite=1 in the first cycle, DECODE next.
- ADD imm (Cond=1110, Op=00, Funct=101001, Rd=3) → FETCH, DECODE, EXECI, ALUWB in 4 cycles; RegWrite=1 only in ALUWB. With ALUFlags=0100 in ALUWB, Flags=0100 afterwards.
- LDR (Op=01, L=1) with MemReady low for 3 cycles in MEMRD → MEMRD held 3 extra cycles with MemReq=1 and RegWrite=0; MEMWB follows with ResultSrc=01.
- BEQ (Cond=0000) with Flags=0000 → DECODE then FETCH, PCWrite=0 in DECODE. With Flags=0100 → BRANCH with PCWrite=1, ImmSrc=10.
- Op=11 with ALLOW_IMM7=1 → DECODE ImmSrc=11, EXECI with ALUControl=00. With ALLOW_IMM7=0 → back to FETCH, no writes.
- Reset pulled low during MEMWR with MemWrite=1 → MemWrite=0 in the same cycle, state FETCH after release.
